// File: rtl/crc_serial_engine.sv
// crc_serial_engine
// Bit-serial CRC engine with a right-shifting LFSR. It has two modes:
//   generate : frame bits are absorbed while Active is high. After Active
//              drops, the CRC is shifted out LSB-first on CRC/Valid.
//   check    : the frame is followed by the sender's CRC, all under Active.
//              After Active drops, Err reports whether the residue is non-zero.
// Ports:
//   CLK      in   rising-edge clock
//   RST      in   asynchronous active-low reset
//   DATA     in   serial frame bit, LSB-first, sampled while Active=1
//   Active   in   frame-in-progress qualifier
//   Mode     in   0 = generate, 1 = check; sampled on the first Active cycle
//   CRC      out  serial CRC bit, LSB-first
//   Valid    out  CRC bit is valid
//   Busy     out  CRC shift-out in progress; Active is ignored
//   Done     out  one-cycle end-of-frame pulse
//   Err      out  check-mode result, 1 = residue non-zero
//   CRC_Par  out  final LFSR value of the last frame
module crc_serial_engine #(
  parameter int                CRC_WD = 8,
  parameter logic [CRC_WD-1:0] POLY   = 8'h44,
  parameter logic [CRC_WD-1:0] SEED   = 8'hD8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DATA,
  input  logic              Active,
  input  logic              Mode,
  output logic              CRC,
  output logic              Valid,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [CRC_WD-1:0] CRC_Par
);

  localparam int CNT_W = $clog2(CRC_WD) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [CRC_WD-1:0]   r_lfsr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_mode;

  // One LFSR step. The feedback bit enters the MSB, and it is XORed into
  // every lower tap selected by POLY.
  function automatic logic [CRC_WD-1:0] lfsr_step(input logic [CRC_WD-1:0] r,
                                                  input logic              d);
    logic fb;
    fb = d ^ r[0];
    return {fb, r[CRC_WD-1:1] ^ (POLY[CRC_WD-2:0] & {(CRC_WD-1){fb}})};
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      CRC     <= 1'b0;
      Valid   <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Err     <= 1'b0;
      CRC_Par <= '0;
    end else begin
      case (r_state)
        // DONE behaves like IDLE, so a frame may start in the DONE cycle.
        // That start gives back-to-back frames with a one-cycle gap.
        S_IDLE, S_DONE: begin
          Valid <= 1'b0;
          Busy  <= 1'b0;
          Done  <= 1'b0;
          CRC   <= 1'b0;
          if (Active) begin
            // The first bit is absorbed on the starting edge.
            r_mode  <= Mode;
            r_lfsr  <= lfsr_step(SEED, DATA);
            r_state <= S_CALC;
          end else begin
            r_lfsr  <= SEED;
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (Active) begin
            r_lfsr <= lfsr_step(r_lfsr, DATA);
          end else begin
            CRC_Par <= r_lfsr;
            if (!r_mode) begin
              r_cnt   <= '0;
              Busy    <= 1'b1;
              r_state <= S_SHIFT;
            end else begin
              Err     <= |r_lfsr;
              Done    <= 1'b1;
              r_lfsr  <= SEED;
              r_state <= S_IDLE;
            end
          end
        end
        S_SHIFT: begin
          // Active and DATA are ignored until the shift-out completes.
          CRC    <= r_lfsr[0];
          r_lfsr <= {1'b0, r_lfsr[CRC_WD-1:1]};
          Valid  <= 1'b1;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(CRC_WD - 1)) begin
            Done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench for crc_serial_engine. Two instances share the stimulus.
// One instance uses the default SEED, and the other uses SEED=0. A schedule
// of expected outputs is built per frame from the CRC arithmetic and the
// frame timing, and one compare process checks it on every falling edge.
module tb_crc_serial_engine;

  localparam int          W    = 8;
  localparam logic [7:0]  POLY = 8'h44;
  localparam int          N    = 1024;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic DATA = 1'b0;
  logic Active = 1'b0;
  logic Mode = 1'b0;

  logic       crc_o   [2];
  logic       valid_o [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic       err_o   [2];
  logic [7:0] par_o   [2];

  crc_serial_engine u_dut0 (
    .CLK(CLK), .RST(RST), .DATA(DATA), .Active(Active), .Mode(Mode),
    .CRC(crc_o[0]), .Valid(valid_o[0]), .Busy(busy_o[0]), .Done(done_o[0]),
    .Err(err_o[0]), .CRC_Par(par_o[0])
  );

  crc_serial_engine #(.SEED(8'h00)) u_dut1 (
    .CLK(CLK), .RST(RST), .DATA(DATA), .Active(Active), .Mode(Mode),
    .CRC(crc_o[1]), .Valid(valid_o[1]), .Busy(busy_o[1]), .Done(done_o[1]),
    .Err(err_o[1]), .CRC_Par(par_o[1])
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Expected-output schedule, indexed by the rising-edge count.
  bit         ev_valid [N];
  bit         ev_busy  [N];
  bit         ev_done  [N];
  bit         ev_crc   [2][N];
  bit         par_set  [N];
  bit         err_set  [N];
  logic [7:0] par_val  [2][N];
  bit         err_val  [2][N];

  logic [7:0] seeds [2];
  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] crc_of(input logic [7:0] seed,
                                        input logic [31:0] v, input int n);
    logic [7:0] r;
    bit fb;
    r = seed;
    for (int i = 0; i < n; i++) begin
      fb = v[i] ^ r[0];
      r  = r >> 1;
      if (fb) r = r ^ (POLY & 8'h7F) ^ 8'h80;
    end
    return r;
  endfunction

  task automatic check(input string name, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, d, cyc, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drives one frame of n bits. The first edge of the frame is the next
  // rising edge. The task returns with Active=0 driven for the frame-end edge.
  task automatic send_frame(input logic [31:0] v, input int n, input logic md);
    int f;
    logic [7:0] cv;
    for (int i = 0; i < n; i++) begin
      Active = 1'b1;
      DATA   = v[i];
      Mode   = (i == 0) ? md : ~md;
      tick(1);
    end
    Active = 1'b0;
    DATA   = 1'b0;
    Mode   = 1'b0;
    f = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      cv = crc_of(seeds[d], v, n);
      par_set[f]    = 1'b1;
      par_val[d][f] = cv;
      if (!md) begin
        for (int i = 0; i < W; i++) ev_crc[d][f+1+i] = cv[i];
      end else begin
        err_set[f]    = 1'b1;
        err_val[d][f] = (cv != 8'h00);
      end
    end
    if (!md) begin
      for (int c = f; c <= f + W; c++) ev_busy[c] = 1'b1;
      for (int i = 0; i < W; i++) ev_valid[f+1+i] = 1'b1;
      ev_done[f+W] = 1'b1;
    end else begin
      ev_done[f] = 1'b1;
    end
  endtask

  task automatic clear_future();
    for (int c = cyc + 1; c < N; c++) begin
      ev_valid[c] = 1'b0; ev_busy[c] = 1'b0; ev_done[c] = 1'b0;
      par_set[c]  = 1'b0; err_set[c] = 1'b0;
      for (int d = 0; d < 2; d++) begin
        ev_crc[d][c] = 1'b0; par_val[d][c] = 8'h00; err_val[d][c] = 1'b0;
      end
    end
  endtask

  // Compare process
  initial begin
    logic [7:0] cur_par [2];
    bit         cur_err [2];
    cur_par[0] = 8'h00; cur_par[1] = 8'h00;
    cur_err[0] = 1'b0;  cur_err[1] = 1'b0;
    forever begin
      @(negedge CLK);
      for (int d = 0; d < 2; d++) begin
        if (!RST) begin
          cur_par[d] = 8'h00;
          cur_err[d] = 1'b0;
        end else begin
          if (par_set[cyc]) cur_par[d] = par_val[d][cyc];
          if (err_set[cyc]) cur_err[d] = err_val[d][cyc];
        end
        check("valid", d, 32'(valid_o[d]), 32'(RST & ev_valid[cyc]));
        check("crc",   d, 32'(crc_o[d]),   32'(RST & ev_crc[d][cyc]));
        check("busy",  d, 32'(busy_o[d]),  32'(RST & ev_busy[cyc]));
        check("done",  d, 32'(done_o[d]),  32'(RST & ev_done[cyc]));
        check("err",   d, 32'(err_o[d]),   32'(cur_err[d]));
        check("par",   d, 32'(par_o[d]),   32'(cur_par[d]));
      end
    end
  end

  // Stimulus
  initial begin
    seeds[0] = 8'hD8;
    seeds[1] = 8'h00;
    tick(3);
    RST = 1'b1;
    tick(1);

    // Pin the model with hand-computed values.
    check("model_a8", 0, 32'(crc_of(8'hD8, 32'h1, 1)), 32'h0000_00A8);
    check("model_6c", 0, 32'(crc_of(8'hD8, 32'h0, 1)), 32'h0000_006C);
    check("model_res0", 0, 32'(crc_of(8'hD8, 32'h151, 9)), 32'h0);

    // 1-bit generate frames
    send_frame(32'h1, 1, 1'b0);
    tick(W + 1);
    check("lit_par_a8", 0, 32'(par_o[0]), 32'h0000_00A8);
    send_frame(32'h0, 1, 1'b0);
    tick(W + 1);
    check("lit_par_6c", 0, 32'(par_o[0]), 32'h0000_006C);

    // Check mode: good frame, then a frame with bit 4 flipped
    send_frame(32'h151, 9, 1'b1);
    tick(1);
    check("lit_err0", 0, 32'(err_o[0]), 32'h0);
    tick(1);
    send_frame(32'h141, 9, 1'b1);
    tick(1);
    check("lit_err1", 0, 32'(err_o[0]), 32'h1);
    tick(1);

    // 16 zero bits: zero CRC on the SEED=0 instance
    send_frame(32'h0, 16, 1'b0);
    tick(W + 1);
    check("lit_par_zero", 1, 32'(par_o[1]), 32'h0);

    // A longer generate frame
    send_frame(32'hC0FF_EE35, 32, 1'b0);
    tick(W + 1);

    // Active held high during Busy with random DATA, then a frame in DONE
    send_frame(32'h1, 1, 1'b0);
    tick(1);
    for (int i = 0; i < W; i++) begin
      Active = 1'b1;
      DATA   = 1'($urandom_range(0, 1));
      Mode   = 1'($urandom_range(0, 1));
      tick(1);
    end
    send_frame(32'h1, 1, 1'b0);
    tick(W + 1);
    check("lit_b2b_a8", 0, 32'(par_o[0]), 32'h0000_00A8);

    // Reset during the 4th Valid cycle
    send_frame(32'h1, 1, 1'b0);
    tick(5);
    RST = 1'b0;
    clear_future();
    #1;
    check("lit_rst_valid", 0, 32'(valid_o[0]), 32'h0);
    check("lit_rst_par",   0, 32'(par_o[0]),   32'h0);
    tick(2);
    RST = 1'b1;
    tick(1);
    send_frame(32'h1, 1, 1'b0);
    tick(W + 1);
    check("lit_post_rst_a8", 0, 32'(par_o[0]), 32'h0000_00A8);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc_serial_engine.md
Name: crc_serial_engine

Overview:
- Parametrised bit-serial CRC engine. Successor to the team's fixed 8-bit serial CRC generator.
- Generalises CRC width, polynomial and seed, and adds a receive-side check mode.
- Adds an explicit FSM, a Busy/Done handshake and a parallel CRC snapshot.
- Sits between the serialiser and line driver (generate mode), or after the deserialiser (check mode).

Parameters:
- CRC_WD, 8: CRC/LFSR width in bits; legal 4..32.
- POLY, 8'h44: feedback tap mask, CRC_WD bits. Bit i set means feedback XORs into R[i] (i < CRC_WD-1).
- SEED, 8'hD8: LFSR preset value, CRC_WD bits.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- DATA  input  1  serial frame bit, LSB-first, sampled while Active=1.
- Active  input  1  frame-in-progress qualifier.
- Mode  input  1  0 = generate, 1 = check. Sampled on the first Active cycle of a frame.
- CRC  output  1  serial CRC bit out, LSB-first.
- Valid  output  1  CRC bit on CRC is valid.
- Busy  output  1  engine is shifting CRC out; Active is ignored.
- Done  output  1  one-cycle end-of-frame pulse.
- Err  output  1  check-mode result, 1 = residue non-zero.
- CRC_Par  output  CRC_WD  final LFSR value of the last frame.

Behaviour:
- Reset (RST=0, async): state=IDLE, R=SEED, CRC=0, Valid=0, Busy=0, Done=0, Err=0, CRC_Par=0, cnt=0, mode_q=0.
- All outputs are registered. R is the internal CRC_WD-bit LFSR.
- LFSR step (CALC):
  - fb = DATA ^ R[0].
  - R[CRC_WD-1] <= fb.
  - R[i] <= R[i+1] ^ (POLY[i] & fb) for i = 0..CRC_WD-2.
- IDLE:
  - Valid=0, Busy=0. R is held at SEED.
  - Edge with Active=1: mode_q<=Mode, apply one LFSR step on DATA, go to CALC. The first bit is not lost.
- CALC:
  - Edge with Active=1: LFSR step.
  - Edge with Active=0: CRC_Par<=R.
    - If mode_q=0: go to SHIFT, cnt<=0, Busy<=1. No CRC bit is emitted on this edge.
    - If mode_q=1: Err<=(R!=0), Done<=1, R<=SEED, go to IDLE.
  - Check mode: the sender's CRC bits are streamed LSB-first after the data, all under Active. A correct frame leaves residue 0.
- SHIFT:
  - Each edge: CRC<=R[0], R<={1'b0, R[CRC_WD-1:1]}, Valid<=1, cnt<=cnt+1.
  - Edge where cnt==CRC_WD-1: last bit is emitted, Done<=1, and the state goes to DONE.
  - Valid is high for exactly CRC_WD consecutive cycles, starting 2 cycles after Active falls.
- DONE (one cycle):
  - Valid<=0, Busy<=0, Done<=0, CRC<=0, R<=SEED, go to IDLE.
  - Active=1 on this edge is treated as IDLE: a new frame starts, giving back-to-back frames with a one-cycle gap.
- Active=1 while Busy=1: DATA is ignored and the shift-out continues undisturbed. Upstream must wait for Busy=0.
- Done:
  - Generate mode: Done is high in the cycle after the last Valid bit, i.e. the DONE-state cycle, and only for that cycle.
  - Check mode: Done is a one-cycle pulse after the Active-falling edge. Err is valid from that cycle and held until the next check-mode Done.
- CRC_Par and Err hold their values until the next frame end.
- Counter width: clog2(CRC_WD)+1 bits. No wrap is possible.
- Reset asserted mid-frame or mid-shift: immediate return to reset values. The partial CRC is discarded.
- Frame length is unbounded. A 1-bit frame is legal. No Active cycles means no activity.

Test Plan:
- Defaults; Active=1 for 1 cycle, DATA=1 -> CRC_Par=8'hA8; Valid high 8 cycles; CRC = 0,0,0,1,0,1,0,1; Done pulse after the last bit; Busy high exactly during shift.
- Defaults; 1 cycle, DATA=0 -> CRC_Par=8'h6C; serial out 0,0,1,1,0,1,1,0.
- Check mode; 9 Active cycles, bits 1,0,0,0,1,0,1,0,1 -> Done pulse, Err=0. Flip the 5th bit -> Err=1.
- SEED=0 override; 16 zero bits -> CRC_Par=0, eight CRC=0 bits with Valid=1.
- Assert Active during Busy with random DATA -> serial CRC unchanged from the first test. Then a new frame starting in the DONE cycle -> correct CRC_Par again (8'hA8 for DATA=1).
- Drop RST during the 4th Valid cycle -> all outputs 0 next sample. A subsequent 1-bit DATA=1 frame gives 8'hA8.
